id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, downstream of the decode-stage control decoder and register file.
- Captures the decoded control bundle, operands, immediate and register indices each cycle, and presents them to the EX stage.
- Owns load-use hazard detection: it raises stall_o to freeze PC and IF/ID, and inserts a bubble into EX.
- Handles flush (taken branch/jump from EX) and an external global hold.

Parameters:
- DATA_W, 32, operand/immediate width
- PC_W, 32, program counter width
- REG_AW, 5, register index width

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- id_valid  input  1  ID holds a real instruction
- id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  input  1 each  decoded controls
- id_ALUOp  input  2  decoded ALU class
- id_JalType  input  2  {JAL, JALR}
- id_pc  input  PC_W  PC of ID instruction
- id_rd1, id_rd2  input  DATA_W  register file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_AW  register indices
- id_funct3  input  3  funct3 field
- id_funct7  input  7  funct7 field
- flush  input  1  EX redirect (taken branch / JAL / JALR)
- hold  input  1  global freeze (e.g. memory wait)
- stall_o  output  1  load-use stall request to PC and IF/ID
- ex_valid  output  1  EX holds a real instruction
- ex_* (one per id_* above except id_valid)  output  same width  registered copy of the control/data field
- bubble_cnt, flush_cnt  output  32  performance counters (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous): every ex_* output, ex_valid and both counters = 0. stall_o = 0 because it derives from ex_valid.
- Latency: one cycle, id_* sampled at clk rise, visible on ex_* after that edge.
- Load-use detect (combinational from registered EX state and current ID inputs):
  - stall_o = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ~flush & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Both rs1 and rs2 are compared regardless of instruction format. The detector is deliberately conservative.
- Bubble = all ex_* control bits 0, ex_ALUOp = 0, ex_JalType = 0, ex_valid = 0, all ex_ data and index fields cleared to 0.
- Per-edge priority, highest first:
  1. Reset.
  2. flush: load a bubble. This overrides hold and stall.
  3. hold: all ex_* registers retain their value. stall_o is still evaluated.
  4. stall_o: load a bubble. The ID instruction stays in IF/ID and re-presents next cycle.
  5. Otherwise load the id_* fields; ex_valid = id_valid.
- id_valid == 0 with no other condition: load the fields with ex_valid = 0 and control bits forced to 0, so no side effects.
- A stall always lasts exactly one cycle per load. After the bubble, ex_valid = 0 and stall_o drops.
- Back-to-back dependent loads (lw x1; lw x2,0(x1)) stall once each.
- flush in the same cycle as a stall condition: stall_o = 0 and a bubble is loaded. The squashed ID instruction must not stall the pipe.
- Reset deasserting mid-stream: the first edge after release performs a normal load.
- No write-enable gating of x0 here; the ex_rd == 0 check only suppresses false stalls.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined:
  - bubble_cnt increments on every edge where a load-use bubble is inserted (priority 4).
  - flush_cnt increments on every edge where flush is applied (priority 2).
  - Both saturate at 32'hFFFF_FFFF, do not count while hold blocks the event, and clear on reset.
- Undefined: bubble_cnt and flush_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset asserted mid-run with ex_RegWrite=1 and ex_pc=0x40 -> immediately all ex_* = 0, ex_valid = 0, stall_o = 0.
- Normal flow: id add x3,x1,x2 at pc 0x10 with id_RegWrite=1, id_ALUOp=2'b10 -> next cycle ex_pc=0x10, ex_rd=3, ex_RegWrite=1, ex_valid=1, stall_o=0.
- Load-use: EX holds lw x5 (ex_MemRead=1, ex_rd=5) and ID presents add x6,x5,x7 -> stall_o=1 in that cycle, next edge bubble (ex_valid=0, all controls 0), then add loads with ex_rd=6; bubble_cnt=1 when ID_EX_PERF_EN is defined.
- x0 guard: EX lw x0 and ID rs1=0 -> stall_o=0 and a normal load.
- Flush+stall collision: load-use condition present with flush=1 -> stall_o=0, bubble loaded, flush_cnt increments, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles with ex_pc=0x20 -> ex_* stable at 0x20. hold=1 with flush=1 -> bubble loaded.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode outputs, detects load-use hazards, handles flush and hold.
// Optional macro ID_EX_PERF_EN builds saturating bubble/flush performance counters.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Branch,
   input  logic [1:0]        id_ALUOp,
   input  logic [1:0]        id_JalType,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              flush,
   input  logic              hold,
   output logic              stall_o,
   output logic              ex_valid,
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Branch,
   output logic [1:0]        ex_ALUOp,
   output logic [1:0]        ex_JalType,
   output logic [PC_W-1:0]   ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       flush_cnt
);

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic [1:0] jal_type;
   } ctrl_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
   } data_t;

   ctrl_t ctrl_q, ctrl_d, id_ctrl_s;
   data_t data_q, data_d, id_data_s;
   logic  valid_q, valid_d;
   logic  stall_s;

   assign id_ctrl_s = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
                       id_MemWrite, id_Branch, id_ALUOp, id_JalType};
   assign id_data_s = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
                       id_funct3, id_funct7};

   // Conservative: rs2 is compared even for formats that do not read it; a squashed ID never stalls.
   assign stall_s = valid_q & ctrl_q.mem_read & (data_q.rd != {REG_AW{1'b0}}) & id_valid & ~flush &
                    ((data_q.rd == id_rs1) | (data_q.rd == id_rs2));
   assign stall_o = stall_s;

   // Next-state selection: flush > hold > load-use bubble > normal capture.
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (flush) begin
         ctrl_d  = '0;
         data_d  = '0;
         valid_d = 1'b0;
      end else if (hold) begin
         ctrl_d  = ctrl_q;
         data_d  = data_q;
         valid_d = valid_q;
      end else if (stall_s) begin
         ctrl_d  = '0;
         data_d  = '0;
         valid_d = 1'b0;
      end else begin
         data_d  = id_data_s;
         valid_d = id_valid;
         if (id_valid) begin
            ctrl_d = id_ctrl_s;
         end else begin
            ctrl_d = '0;
         end
      end
   end

   // Pipeline register state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_ALUSrc   = ctrl_q.alu_src;
   assign ex_MemtoReg = ctrl_q.mem_to_reg;
   assign ex_RegWrite = ctrl_q.reg_write;
   assign ex_MemRead  = ctrl_q.mem_read;
   assign ex_MemWrite = ctrl_q.mem_write;
   assign ex_Branch   = ctrl_q.branch;
   assign ex_ALUOp    = ctrl_q.alu_op;
   assign ex_JalType  = ctrl_q.jal_type;
   assign ex_pc       = data_q.pc;
   assign ex_rd1      = data_q.rd1;
   assign ex_rd2      = data_q.rd2;
   assign ex_imm      = data_q.imm;
   assign ex_rs1      = data_q.rs1;
   assign ex_rs2      = data_q.rs2;
   assign ex_rd       = data_q.rd;
   assign ex_funct3   = data_q.funct3;
   assign ex_funct7   = data_q.funct7;

`ifdef ID_EX_PERF_EN
   logic [31:0] bubble_cnt_q, flush_cnt_q;
   logic        bubble_evt_s;

   // A stall blocked by hold inserts no bubble, so it is not counted.
   assign bubble_evt_s = stall_s & ~hold;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_cnt_q <= 32'd0;
         flush_cnt_q  <= 32'd0;
      end else begin
         if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
         if (bubble_evt_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`else
   assign bubble_cnt = 32'd0;
   assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed plan scenarios plus randomized traffic against a
// record-level reference model of the EX slot.
module tb_id_ex_stage;

   logic        clk, reset, id_valid;
   logic        id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
   logic [1:0]  id_ALUOp, id_JalType;
   logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   logic        flush, hold;
   logic        stall_o, ex_valid;
   logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
   logic [1:0]  ex_ALUOp, ex_JalType;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [31:0] bubble_cnt, flush_cnt;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
      .id_ALUOp(id_ALUOp), .id_JalType(id_JalType), .id_pc(id_pc),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7(id_funct7),
      .flush(flush), .hold(hold), .stall_o(stall_o), .ex_valid(ex_valid),
      .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
      .ex_ALUOp(ex_ALUOp), .ex_JalType(ex_JalType), .ex_pc(ex_pc),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   // ctl layout: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], JalType[1:0]}
   typedef struct packed {
      logic [9:0]  ctl;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
   } rec_t;

   localparam logic [9:0] CTL_ADD = 10'b0010_0010_00;
   localparam logic [9:0] CTL_LW  = 10'b1111_0000_00;

   rec_t        m_ex;
   logic        m_valid;
   logic [31:0] m_bub, m_fl;
   int          n_checks, n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic rec_t id_rec();
      rec_t r;
      r.ctl = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch,
               id_ALUOp, id_JalType};
      r.pc = id_pc; r.rd1 = id_rd1; r.rd2 = id_rd2; r.imm = id_imm;
      r.rs1 = id_rs1; r.rs2 = id_rs2; r.rd = id_rd; r.f3 = id_funct3; r.f7 = id_funct7;
      return r;
   endfunction

   // EX holds a live load that writes a nonzero register the live, unsquashed ID instruction reads.
   function automatic logic model_stall();
      logic ex_is_load, id_reads_it;
      ex_is_load  = m_valid && m_ex.ctl[6] && (m_ex.rd != 5'd0);
      id_reads_it = (id_rs1 == m_ex.rd) || (id_rs2 == m_ex.rd);
      return ex_is_load && id_reads_it && id_valid && !flush;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_clear();
      m_ex = '0; m_valid = 1'b0; m_bub = 32'd0; m_fl = 32'd0;
   endtask

   task automatic model_edge(input logic stall_now);
      if (flush) begin
         m_ex = '0; m_valid = 1'b0;
`ifdef ID_EX_PERF_EN
         m_fl = sat_inc(m_fl);
`endif
      end else if (hold) begin
         m_valid = m_valid;
      end else if (stall_now) begin
         m_ex = '0; m_valid = 1'b0;
`ifdef ID_EX_PERF_EN
         m_bub = sat_inc(m_bub);
`endif
      end else begin
         m_ex = id_rec();
         m_valid = id_valid;
         if (!id_valid) m_ex.ctl = 10'd0;
      end
   endtask

   task automatic compare_all();
      check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
      check_eq("ex_ctl", {54'd0, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                          ex_Branch, ex_ALUOp, ex_JalType}, {54'd0, m_ex.ctl});
      check_eq("ex_pc", {32'd0, ex_pc}, {32'd0, m_ex.pc});
      check_eq("ex_rd1", {32'd0, ex_rd1}, {32'd0, m_ex.rd1});
      check_eq("ex_rd2", {32'd0, ex_rd2}, {32'd0, m_ex.rd2});
      check_eq("ex_imm", {32'd0, ex_imm}, {32'd0, m_ex.imm});
      check_eq("ex_regs", {49'd0, ex_rs1, ex_rs2, ex_rd}, {49'd0, m_ex.rs1, m_ex.rs2, m_ex.rd});
      check_eq("ex_funct", {54'd0, ex_funct3, ex_funct7}, {54'd0, m_ex.f3, m_ex.f7});
      check_eq("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_bub});
      check_eq("flush_cnt", {32'd0, flush_cnt}, {32'd0, m_fl});
   endtask

   task automatic drive_id(input logic v, input logic [9:0] c, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      id_valid = v;
      {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch,
       id_ALUOp, id_JalType} = c;
      id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
      id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
   endtask

   // Called just after a negedge with inputs driven; returns just after the next negedge.
   task automatic step();
      logic s;
      #1;
      s = model_stall();
      check_eq("stall_o", {63'd0, stall_o}, {63'd0, s});
      @(posedge clk);
      model_edge(s);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      model_clear();
      compare_all();
      check_eq("rst_stall_o", {63'd0, stall_o}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      model_clear();
      reset = 1'b0; flush = 1'b0; hold = 1'b0;
      drive_id(1'b0, 10'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      compare_all();
      check_eq("rst_stall_o", {63'd0, stall_o}, 64'd0);
      reset = 1'b1;

      // Normal flow: add x3,x1,x2 @0x10
      drive_id(1'b1, CTL_ADD, 32'h10, 5'd1, 5'd2, 5'd3);
      step();
      check_eq("add_pc", {32'd0, ex_pc}, 64'h10);
      check_eq("add_rd", {59'd0, ex_rd}, 64'd3);
      check_eq("add_valid", {63'd0, ex_valid}, 64'd1);

      // Reset mid-run with RegWrite=1 and pc 0x40 in EX
      drive_id(1'b1, CTL_ADD, 32'h40, 5'd1, 5'd2, 5'd4);
      step();
      async_reset();
      check_eq("rst_pc", {32'd0, ex_pc}, 64'd0);

      // Load-use: lw x5 then add x6,x5,x7
      drive_id(1'b1, CTL_LW, 32'h100, 5'd1, 5'd0, 5'd5);
      step();
      drive_id(1'b1, CTL_ADD, 32'h104, 5'd5, 5'd7, 5'd6);
      #1 check_eq("lu_stall", {63'd0, stall_o}, 64'd1);
      step();
      check_eq("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
      step();
      check_eq("lu_add_rd", {59'd0, ex_rd}, 64'd6);
`ifdef ID_EX_PERF_EN
      check_eq("lu_bubble_cnt", {32'd0, bubble_cnt}, 64'd1);
`endif

      // x0 guard: lw x0 then rs1=0
      drive_id(1'b1, CTL_LW, 32'h200, 5'd1, 5'd0, 5'd0);
      step();
      drive_id(1'b1, CTL_ADD, 32'h204, 5'd0, 5'd0, 5'd9);
      step();
      check_eq("x0_valid", {63'd0, ex_valid}, 64'd1);

      // Back-to-back dependent loads, then a consumer of the second
      drive_id(1'b1, CTL_LW, 32'h300, 5'd2, 5'd0, 5'd1);
      step();
      drive_id(1'b1, CTL_LW, 32'h304, 5'd1, 5'd0, 5'd2);
      step(); step();
      drive_id(1'b1, CTL_ADD, 32'h308, 5'd2, 5'd3, 5'd4);
      step(); step();

      // Flush colliding with a load-use condition
      drive_id(1'b1, CTL_LW, 32'h400, 5'd1, 5'd0, 5'd5);
      step();
      drive_id(1'b1, CTL_ADD, 32'h404, 5'd5, 5'd7, 5'd6);
      flush = 1'b1;
      #1 check_eq("fl_stall", {63'd0, stall_o}, 64'd0);
      step();
      flush = 1'b0;

      // Hold for 3 cycles with pc 0x20 in EX, then hold+flush
      drive_id(1'b1, CTL_ADD, 32'h20, 5'd1, 5'd2, 5'd3);
      step();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, CTL_ADD, $urandom, 5'd8, 5'd9, 5'd10);
         step();
      end
      check_eq("hold_pc", {32'd0, ex_pc}, 64'h20);
      flush = 1'b1;
      step();
      check_eq("holdfl_valid", {63'd0, ex_valid}, 64'd0);
      flush = 1'b0; hold = 1'b0;

      // Randomized traffic with small register indices to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         drive_id(($urandom_range(0, 7) != 0), 10'($urandom), $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         flush = ($urandom_range(0, 9) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
         end else begin
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
